// File: rtl/sequence_generator.sv
// Repeating 8-entry byte pattern source: steps one entry per enabled clock
// and holds otherwise. The output is fully registered.
module sequence_generator (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] data
);

  // Index of the next byte to emit. Position lives here because 0xE2 appears
  // twice in the pattern, so the position cannot be recovered from data.
  logic [2:0] ptr;

  // Fixed pattern held as combinational constants rather than a register file.
  function automatic logic [7:0] seq_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = 8'hAF;
      3'd1: b = 8'hBC;
      3'd2: b = 8'hE2;
      3'd3: b = 8'h78;
      3'd4: b = 8'hFF;
      3'd5: b = 8'hE2;
      3'd6: b = 8'h0B;
      3'd7: b = 8'h8D;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // NOTE: state registers use non-blocking assignments so that data and ptr
  // both see the pre-edge value of ptr, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= 3'd0;
      data <= 8'h00;
    end else if (enable) begin
      data <= seq_byte(ptr);
      ptr  <= ptr + 3'd1;  // 7 -> 0 by natural 3-bit overflow
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: an enabled-edge-count model
// checked every cycle, plus directed vectors with literal expectations.
module tb_sequence_generator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] seq_tbl [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Model state: enabled edges seen since the last reset edge.
  int  en_count = 0;
  logic checking = 1'b0;

  sequence_generator dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .data   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_data(input int k);
    if (k == 0) return 8'h00;
    return seq_tbl[(k - 1) % 8];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: data=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, so they are stable here.
  always @(posedge clk) begin
    if (reset)       en_count <= 0;
    else if (enable) en_count <= en_count + 1;
  end

  always @(negedge clk) begin
    if (checking) check("model", data, model_data(en_count));
  end

  task automatic step(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;

    // Reset then hold
    step(1'b1, 1'b0);
    checking = 1'b1;
    check("reset_edge1", data, 8'h00);
    step(1'b1, 1'b0);
    check("reset_edge2", data, 8'h00);
    step(1'b0, 1'b0);
    check("post_reset_hold1", data, 8'h00);
    step(1'b0, 1'b0);
    check("post_reset_hold2", data, 8'h00);

    // Single pass, then repetition and wrap
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("pass_idx%0d", i), data, seq_tbl[i % 8]);
    end
    check("wrap_end_8d", data, 8'h8D);

    // Disable/hold, then re-enable after 0x8D
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("hold_8d", data, 8'h8D);
    end
    step(1'b0, 1'b1);
    check("resume_af", data, 8'hAF);

    // Pause mid-sequence
    step(1'b1, 1'b0);
    check("reset_again", data, 8'h00);
    step(1'b0, 1'b1);
    check("pause_af", data, 8'hAF);
    step(1'b0, 1'b1);
    check("pause_bc", data, 8'hBC);
    step(1'b0, 1'b1);
    check("pause_e2", data, 8'hE2);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("gap_e2", data, 8'hE2);
    end
    step(1'b0, 1'b1);
    check("after_gap_78", data, 8'h78);
    step(1'b0, 1'b1);
    check("after_gap_ff", data, 8'hFF);

    // Reset mid-operation with enable high
    step(1'b1, 1'b1);
    check("reset_over_enable", data, 8'h00);
    step(1'b0, 1'b0);
    check("after_reset_idle", data, 8'h00);
    step(1'b0, 1'b1);
    check("after_reset_af", data, 8'hAF);

    // Irregular enable pattern, checked by the per-cycle model
    for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)));

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
